// File: rtl/dm_cache_if.sv
// Bus bundles for dm_cache: CPU-side load/store port and
// memory-side word req/ack port.
interface dm_cpu_if #(
    parameter int ADDR_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [3:0]        cpu_wstrb;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;

    modport master (
        output cpu_req, cpu_we, cpu_wstrb, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_wstrb, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall
    );
endinterface

interface dm_mem_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache
// between the MEM stage and unified memory.
module dm_cache #(
    parameter int LINES  = 16,
    parameter int WPL    = 4,
    parameter int ADDR_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    dm_cpu_if.slave       cpu,
    dm_mem_if.master      mem,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
);
    localparam int OW = $clog2(WPL);
    localparam int IW = $clog2(LINES);
    localparam int LB = OW + 2;
    localparam int TW = ADDR_W - LB - IW;

    typedef enum logic [1:0] {
        IDLE, REFILL, WRITE, RESP
    } state_e;

    state_e            state_q;
    logic [LINES-1:0]  valid_q;
    logic [TW-1:0]     tag_q [LINES];
    logic [31:0]       data_q [LINES][WPL];
    logic [OW-1:0]     beat_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_wstrb_q;
    logic [31:0]       mem_wdata_q;
    logic [15:0]       hit_q, hit_d;
    logic [15:0]       miss_q, miss_d;

    logic [OW-1:0] wrd;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          hit;
    logic          ack;
    logic          last;
    logic          unused_addr;

    assign wrd  = cpu.cpu_addr[LB-1:2];
    assign idx  = cpu.cpu_addr[LB+IW-1:LB];
    assign tag  = cpu.cpu_addr[ADDR_W-1:LB+IW];
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign ack  = mem_req_q & mem.mem_ack;
    assign last = (beat_q == OW'(WPL - 1));
    assign unused_addr = ^cpu.cpu_addr[1:0];

    assign hit_d  = (hit_q == 16'hFFFF) ? hit_q : hit_q + 16'd1;
    assign miss_d = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;

    // Outputs are forced quiet while reset is held.
    assign cpu.cpu_stall = rst & (
        ((state_q == IDLE) & cpu.cpu_req & (cpu.cpu_we | ~hit)) |
        (state_q == REFILL) | (state_q == WRITE));
    assign cpu.cpu_rdata = rst ? data_q[idx][wrd] : 32'd0;

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wstrb = mem_wstrb_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign hit_cnt       = hit_q;
    assign miss_cnt      = miss_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            beat_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu.cpu_req) begin
                        if (hit) hit_q <= hit_d;
                        else     miss_q <= miss_d;
                        if (cpu.cpu_we) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {cpu.cpu_addr[ADDR_W-1:2], 2'b00};
                            mem_wstrb_q <= cpu.cpu_wstrb;
                            mem_wdata_q <= cpu.cpu_wdata;
                            state_q     <= WRITE;
                        end else if (!hit) begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {cpu.cpu_addr[ADDR_W-1:LB], {LB{1'b0}}};
                            beat_q     <= '0;
                            state_q    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (ack) begin
                        beat_q     <= beat_q + OW'(1);
                        mem_addr_q <= mem_addr_q + ADDR_W'(4);
                        if (last) begin
                            mem_req_q    <= 1'b0;
                            valid_q[idx] <= 1'b1;
                            tag_q[idx]   <= tag;
                            state_q      <= RESP;
                        end
                    end
                end
                WRITE: begin
                    if (ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line data: refill beats and store-hit byte merges.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == REFILL && ack) begin
                data_q[idx][beat_q] <= mem.mem_rdata;
            end else if (state_q == IDLE && cpu.cpu_req &&
                         cpu.cpu_we && hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (cpu.cpu_wstrb[b]) begin
                        data_q[idx][wrd][8*b +: 8] <= cpu.cpu_wdata[8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_cache.sv
// Scoreboard bench for dm_cache: directed loads/stores against a
// word memory model with configurable wait states.
module tb_dm_cache;
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    dm_cpu_if #(.ADDR_W(16)) cpu_bus ();
    dm_mem_if #(.ADDR_W(16)) mem_bus ();

    dm_cache #(.LINES(16), .WPL(4), .ADDR_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (cpu_bus),
        .mem      (mem_bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          waits = 0;
    int          wcnt = 0;
    bit          spurious = 1'b0;
    bit          mon_en = 1'b1;
    logic [31:0] exp_q [$];
    txn_t        log_q [$];
    logic [31:0] mem_m [int];
    logic [31:0] wtmp;
    txn_t        t;

    function automatic logic [31:0] rd(input logic [15:0] a);
        if (mem_m.exists(int'(a))) return mem_m[int'(a)];
        return {16'hDEAD, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Memory model: ack decided on the falling edge for the next rise.
    always @(negedge clk) begin
        if (mem_bus.mem_req) begin
            mem_bus.mem_ack   = (wcnt == waits);
            mem_bus.mem_rdata = rd(mem_bus.mem_addr);
        end else begin
            mem_bus.mem_ack   = spurious;
            mem_bus.mem_rdata = 32'h0;
        end
    end

    always @(posedge clk) begin
        if (rst && mem_bus.mem_req && mem_bus.mem_ack) begin
            t.we   = mem_bus.mem_we;
            t.addr = mem_bus.mem_addr;
            t.strb = mem_bus.mem_wstrb;
            t.data = mem_bus.mem_wdata;
            log_q.push_back(t);
            if (mem_bus.mem_we) begin
                wtmp = rd(mem_bus.mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_bus.mem_wstrb[b])
                        wtmp[8*b +: 8] = mem_bus.mem_wdata[8*b +: 8];
                mem_m[int'(mem_bus.mem_addr)] = wtmp;
            end
            wcnt = 0;
        end else if (mem_bus.mem_req) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: every delivered load word is checked against the queue.
    always @(negedge clk) begin
        if (mon_en && rst && cpu_bus.cpu_req && !cpu_bus.cpu_we &&
            !cpu_bus.cpu_stall) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rdata_unexpected: got %h, required no response",
                         cpu_bus.cpu_rdata);
            end else begin
                wtmp = exp_q.pop_front();
                if (cpu_bus.cpu_rdata !== wtmp) begin
                    miscompares++;
                    $display("FAIL rdata @%h: got %h, required %h",
                             cpu_bus.cpu_addr, cpu_bus.cpu_rdata, wtmp);
                end
            end
        end
    end

    task automatic op(input bit we, input logic [15:0] a,
                      input logic [3:0] s, input logic [31:0] wd,
                      input logic [31:0] ex, output int stalls);
        int n;
        bit done;
        @(posedge clk); #1;
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_addr  = a;
        cpu_bus.cpu_wstrb = s;
        cpu_bus.cpu_wdata = wd;
        if (!we) exp_q.push_back(ex);
        stalls = 0;
        done = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (cpu_bus.cpu_stall) stalls++;
            else done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL op_timeout @%h: stalled %0d cycles, required release",
                     a, n);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cpu_bus.cpu_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic chk_refill(input string name, input logic [15:0] base);
        chk({name, "_beats"}, log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                chk({name, "_addr"}, log_q[i].addr, base + 16'(4 * i));
                chk({name, "_we"}, log_q[i].we, 0);
            end
        end
    endtask

    initial begin
        int st;
        int n;
        mem_m[32'h8000] = 32'h11111111;
        mem_m[32'h8004] = 32'h22222222;
        mem_m[32'h8008] = 32'h33333333;
        mem_m[32'h800C] = 32'h44444444;
        mem_m[32'h9000] = 32'h99990000;
        mem_m[32'h9004] = 32'h99990004;
        mem_m[32'h9008] = 32'h99990008;
        mem_m[32'h900C] = 32'h9999000C;
        cpu_bus.cpu_req   = 1'b0;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_addr  = '0;
        cpu_bus.cpu_wstrb = '0;
        cpu_bus.cpu_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_bus.mem_req, 0);
        chk("rst_mem_addr", mem_bus.mem_addr, 0);
        chk("rst_hit", hit_cnt, 0);
        chk("rst_miss", miss_cnt, 0);
        chk("rst_stall", cpu_bus.cpu_stall, 0);
        rst = 1'b1;

        // Cold miss, then hit in the same line
        log_q.delete();
        op(0, 16'h8000, 4'h0, 0, 32'h11111111, st);
        chk("cold_stall", st, 5);
        chk_refill("cold", 16'h8000);
        op(0, 16'h8008, 4'h0, 0, 32'h33333333, st);
        chk("hit_stall", st, 0);
        tick();
        chk("miss_cnt1", miss_cnt, 1);
        chk("hit_cnt1", hit_cnt, 1);

        // Store hit, then load visible in the cycle after RESP
        log_q.delete();
        op(1, 16'h8004, 4'b0011, 32'hAABBCCDD, 0, st);
        chk("st_hit_stall", st, 2);
        op(0, 16'h8004, 4'h0, 0, 32'h2222CCDD, st);
        chk("st_ld_stall", st, 0);
        tick();
        chk("st_hit_txns", log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk("st_hit_we", log_q[0].we, 1);
            chk("st_hit_addr", log_q[0].addr, 16'h8004);
            chk("st_hit_strb", log_q[0].strb, 4'b0011);
            chk("st_hit_data", log_q[0].data, 32'hAABBCCDD);
        end
        chk("hit_cnt3", hit_cnt, 3);

        // Store miss: one write, no allocate
        log_q.delete();
        op(1, 16'h9000, 4'hF, 32'h5A5A5A5A, 0, st);
        chk("st_miss_stall", st, 2);
        tick();
        chk("st_miss_txns", log_q.size(), 1);
        if (log_q.size() > 0) chk("st_miss_we", log_q[0].we, 1);
        chk("miss_cnt2", miss_cnt, 2);
        log_q.delete();
        op(0, 16'h9000, 4'h0, 0, 32'h5A5A5A5A, st);
        chk("ld9000_stall", st, 5);
        chk_refill("ld9000", 16'h9000);
        tick();
        chk("miss_cnt3", miss_cnt, 3);

        // Index-0 conflict thrash
        do_reset();
        log_q.delete();
        op(0, 16'h8000, 4'h0, 0, 32'h11111111, st);
        op(0, 16'h9000, 4'h0, 0, 32'h5A5A5A5A, st);
        op(0, 16'h8000, 4'h0, 0, 32'h11111111, st);
        chk("conf_stall", st, 5);
        tick();
        chk("conf_miss", miss_cnt, 3);
        chk("conf_beats", log_q.size(), 12);

        // Three wait cycles per beat, then reset mid-refill
        waits = 3;
        do_reset();
        op(0, 16'h8000, 4'h0, 0, 32'h11111111, st);
        chk("wait3_stall", st, 17);
        tick();
        log_q.delete();
        @(posedge clk); #1;
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_we   = 1'b0;
        cpu_bus.cpu_addr = 16'h9000;
        n = 0;
        while (log_q.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (log_q.size() < 2) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_wait: got %0d beats, required 2", log_q.size());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_mem_req", mem_bus.mem_req, 0);
        chk("midrst_stall", cpu_bus.cpu_stall, 0);
        chk("midrst_rdata", cpu_bus.cpu_rdata, 0);
        chk("midrst_beats", log_q.size(), 2);
        rst = 1'b1;
        cpu_bus.cpu_req = 1'b0;
        op(0, 16'h8000, 4'h0, 0, 32'h11111111, st);
        chk("postrst_stall", st, 17);
        tick();
        chk("postrst_miss", miss_cnt, 1);
        waits = 0;

        // Hit counter saturation
        @(posedge clk); #1;
        mon_en = 1'b0;
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_we   = 1'b0;
        cpu_bus.cpu_addr = 16'h8000;
        repeat (65534) @(posedge clk);
        #1;
        cpu_bus.cpu_req = 1'b0;
        mon_en = 1'b1;
        chk("hit_fffe", hit_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            op(0, 16'h8000, 4'h0, 0, 32'h11111111, st);
            chk("sat_stall", st, 0);
        end
        tick();
        chk("hit_sat", hit_cnt, 16'hFFFF);
        chk("miss_after_sat", miss_cnt, 1);

        // Stray ack with no request
        log_q.delete();
        spurious = 1'b1;
        repeat (3) tick();
        spurious = 1'b0;
        chk("stray_txns", log_q.size(), 0);
        chk("stray_mem_req", mem_bus.mem_req, 0);
        op(0, 16'h8008, 4'h0, 0, 32'h33333333, st);
        chk("stray_hit_stall", st, 0);
        tick();
        chk("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dm_cache.md
# dm_cache

Direct-mapped, write-through, no-write-allocate data cache placed between the CPU MEM stage and the unified byte-addressed memory in `Top`. It absorbs data loads and stores from the pipeline. On misses and stores it asserts `cpu_stall`, which feeds the pipeline's `Stall_MA`. It runs word transactions to memory over a req/ack handshake. Hit and miss counters are exposed for the simulation monitor.

## Interface
Parameters:
- `LINES`, 16: number of cache lines (power of 2).
- `WPL`, 4: 32-bit words per line.
- `ADDR_W`, 16: byte-address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `cpu_req`  in  1  load/store request from the MEM stage.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_wstrb`  in  4  byte enables for stores.
- `cpu_addr`  in  ADDR_W  byte address; bits [1:0] ignored.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data; valid when `cpu_req & ~cpu_we & ~cpu_stall`.
- `cpu_stall`  out  1  hold the pipeline.
- `mem_req`  out  1  memory request (registered).
- `mem_we`  out  1  memory write (registered).
- `mem_addr`  out  ADDR_W  word-aligned address (registered).
- `mem_wstrb`  out  4  byte enables (registered).
- `mem_wdata`  out  32  write data (registered).
- `mem_rdata`  in  32  read data; valid with `mem_ack`.
- `mem_ack`  in  1  a beat completes on any cycle where `mem_req & mem_ack`.
- `hit_cnt`  out  16  saturating hit counter.
- `miss_cnt`  out  16  saturating miss counter.

## Operation
- Address split for the defaults:
  - [1:0] byte offset.
  - [3:2] word within line.
  - [7:4] index.
  - [15:8] tag.
- Per-line storage: valid bit, tag, `WPL` data words.
- Hit = `valid[idx] && tag[idx]==addr_tag`.
- States: IDLE, REFILL, WRITE, RESP.
- IDLE, no `cpu_req`: stall 0; no action.
- IDLE, load hit:
  - `cpu_rdata` = stored word, combinational.
  - Stall 0; `hit_cnt`+1.
- IDLE, load miss:
  - Stall 1; `miss_cnt`+1.
  - Latch line base; `beat`=0.
  - Next state REFILL.
- REFILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = base + 4·`beat`.
  - On ack: write `mem_rdata` into word `beat`, then `beat`+1.
  - On the last ack: set valid and tag, go to RESP.
  - Stall 1 throughout.
- IDLE, store (hit or miss):
  - Stall 1.
  - Latch address, strobes and data; go to WRITE.
  - Hit: count `hit_cnt`, and merge the strobed bytes into the line on that same edge.
  - Miss: count `miss_cnt`; line contents untouched (no allocate).
- WRITE:
  - `mem_req`=1, `mem_we`=1, with the latched address, strobes and data.
  - On ack go to RESP. Stall 1.
- RESP:
  - Stall 0, for exactly one cycle.
  - For a load, `cpu_rdata` = the requested word.
  - The request present this cycle is retired and not re-processed. No counter update.
  - Next state IDLE.
- `mem_req` stays high across consecutive refill beats. Address and data stay stable until ack.
- Both counters saturate at 16'hFFFF.
- The CPU holds `cpu_req`, `cpu_we`, `cpu_addr`, `cpu_wstrb` and `cpu_wdata` stable while stalled. The cache does not re-sample them outside IDLE.

## Timing
- Reset (`rst`=0 at an edge):
  - All valid bits cleared; state IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata` = 0.
  - `hit_cnt` = `miss_cnt` = 0; `beat`=0.
  - `cpu_stall` = 0 and `cpu_rdata` = 0 while in reset.
- Reset asserted mid-REFILL or mid-WRITE:
  - The transaction is abandoned and `mem_req` drops on that edge.
  - The partially filled line stays invalid.
- Load hit: 0 stall cycles.
- Load miss with zero-wait memory (ack in the same cycle as req):
  - Stall for 1 + `WPL` = 5 cycles.
  - RESP in the 6th cycle.
- Each extra wait cycle per beat adds one stall cycle.
- Store with zero-wait memory: 2 stall cycles, then RESP.
- Data stored by a store hit is visible to a load in the cycle after RESP.
- `mem_ack` while `mem_req`=0 is ignored.

## Test plan
- Reset, then load 0x8000 (cold), zero-wait memory returning 0x11111111/0x22222222/0x33333333/0x44444444:
  - `mem_addr` 0x8000, 0x8004, 0x8008, 0x800C.
  - Stall 5 cycles, RESP `cpu_rdata`=0x11111111, `miss_cnt`=1.
  - Then load 0x8008: 0 stalls, 0x33333333, `hit_cnt`=1.
- Store 0xAABBCCDD with wstrb 0011 to 0x8004 (hit):
  - Memory sees write 0x8004, strb 0011.
  - A following load 0x8004 returns 0x2222CCDD with no refill.
- Store to 0x9000 (miss):
  - Exactly one memory write, no refill.
  - A load 0x9000 then misses and refills.
- Conflict on index 0: load 0x8000, then load 0x9000, then load 0x8000 → three refills, `miss_cnt`=3.
- Memory with 3 wait cycles per beat:
  - Load miss stalls 1 + 4·4 = 17 cycles.
  - Assert `rst`=0 during beat 2 → `mem_req` low next cycle; a following load 0x8000 misses.
- Force `hit_cnt` to 0xFFFE, then three load hits → `hit_cnt` holds at 0xFFFF.
